// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM-side streaming blocks.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int unsigned SKID_ENTRIES = 2;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry output FIFO with fall-through: a word pushed into an empty FIFO
// is presented in the same cycle, so the RAM read latency is not extended.
module stream_skid_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic              empty, wr_en, rd_en;

  assign empty = (occ == 2'd0);
  // A fall-through word popped in its arrival cycle never needs storing.
  assign wr_en = push && !(empty && pop);
  assign rd_en = pop && !empty;

  assign valid = !empty || push;
  assign dout  = !empty ? mem[rd_ptr] : (push ? din : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a single-port BRAM (1-cycle read latency) and
// streams them out over a valid/ready interface with back-pressure.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  rd_state_t             state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q, issued_q, beats_q;
  logic                  inflight_q, done_q;
  logic [1:0]            occ;
  logic [2:0]            tot;
  logic                  pop, room, issue, last_issue, last_beat, accept;

  assign pop        = m_valid && m_ready;
  // Words held or on their way: stored entries plus the read in flight.
  assign tot        = {1'b0, occ} + {2'b00, inflight_q};
  assign room       = pop ? (tot < 3'd3) : (tot < 3'd2);
  assign issue      = (state == ST_READ) && room;
  assign last_issue = (issued_q == len_q - 1'b1);
  assign last_beat  = (beats_q == len_q - 1'b1);
  assign accept     = (state == ST_IDLE) && start;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start && length != '0) nxt = ST_READ;
      ST_READ:  if (issue && last_issue)   nxt = ST_DRAIN;
      ST_DRAIN: if (pop && last_beat)      nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= nxt;
      inflight_q <= issue;
      done_q     <= (accept && length == '0) ||
                    (state == ST_DRAIN && pop && last_beat);
      if (accept) begin
        addr_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
        beats_q  <= '0;
      end else begin
        if (issue) begin
          addr_q   <= (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        if (pop) beats_q <= beats_q + 1'b1;
      end
    end
  end

  stream_skid_fifo2 #(.W(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (ram_dout),
    .pop   (pop),
    .dout  (m_data),
    .valid (m_valid),
    .occ   (occ)
  );

  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign ram_en   = issue;
  assign ram_we   = 1'b0;
  assign ram_addr = addr_q;
  assign m_last   = m_valid && last_beat;

endmodule
